// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO poll sequencer: FSM states, Avalon
// command payload and the helper that maps a state to its bus command.
package pio_poll_pkg;

   localparam int unsigned AVM_ADDR_W = 32;
   localparam int unsigned AVM_DATA_W = 32;
   localparam int unsigned LED_W      = 8;
   localparam int unsigned COUNT_W    = 16;

   localparam logic [AVM_ADDR_W-1:0] DEFAULT_BTN_ADDR = 32'h0000_0000;
   localparam logic [AVM_ADDR_W-1:0] DEFAULT_LED_ADDR = 32'h0000_0010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_WAIT = 2'd2,
      WR_REQ  = 2'd3
   } state_t;

   typedef struct packed {
      logic [AVM_ADDR_W-1:0] address;
      logic [AVM_DATA_W-1:0] writedata;
      logic                  read;
      logic                  write;
   } avm_cmd_t;

   // Bus command presented while sitting in a given state; all-zero when idle.
   function automatic avm_cmd_t cmd_for(input state_t                s,
                                        input logic [AVM_ADDR_W-1:0] btn_addr,
                                        input logic [AVM_ADDR_W-1:0] led_addr,
                                        input logic [LED_W-1:0]      data);
      avm_cmd_t c;
      c = '0;
      case (s)
         RD_REQ: begin
            c.address = btn_addr;
            c.read    = 1'b1;
         end
         WR_REQ: begin
            c.address   = led_addr;
            c.writedata = AVM_DATA_W'(data);
            c.write     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pio_poll_sequencer_if.sv
// Avalon-MM master/slave bundle between the poll sequencer and the PIO fabric.
interface pio_poll_sequencer_if;
   import pio_poll_pkg::*;

   logic [AVM_ADDR_W-1:0] avm_address;
   logic                  avm_read;
   logic                  avm_write;
   logic [AVM_DATA_W-1:0] avm_writedata;
   logic [AVM_DATA_W-1:0] avm_readdata;
   logic                  avm_waitrequest;
   logic                  avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      output avm_write,
      output avm_writedata,
      input  avm_readdata,
      input  avm_waitrequest,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_write,
      input  avm_writedata,
      output avm_readdata,
      output avm_waitrequest,
      output avm_readdatavalid
   );

endinterface

// File: rtl/pio_poll_sequencer_poll_timer.sv
// Periodic tick generator: one-cycle tick every POLL_CYCLES clocks while enabled.
module poll_timer #(
   parameter int unsigned POLL_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam int unsigned     CNT_W  = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // tick is registered so it is high exactly in the cycle the count sits at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (!enable) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt - CNT_W'(1);
         tick <= (cnt == CNT_W'(1));
      end
   end

endmodule

// File: rtl/pio_poll_sequencer.sv
// Avalon-MM master that polls the buttons PIO and mirrors changed low bits to the LEDs PIO.
module pio_poll_sequencer
   import pio_poll_pkg::*;
#(
   parameter int unsigned           POLL_CYCLES    = 50000,
   parameter logic [AVM_ADDR_W-1:0] BTN_ADDR       = DEFAULT_BTN_ADDR,
   parameter logic [AVM_ADDR_W-1:0] LED_ADDR       = DEFAULT_LED_ADDR,
   parameter int unsigned           TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   pio_poll_sequencer_if.master  bus,
   output logic [LED_W-1:0]      last_value,
   output logic                  change_pulse,
   output logic [COUNT_W-1:0]    change_count,
   output logic                  busy,
   output logic                  err_timeout
);

   localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [LED_W-1:0]  sample_q, sample_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              first_poll_q;
   avm_cmd_t          cmd_q, cmd_d;
   logic              tick;
   logic              wr_done;
   logic              timeout_hit;
   logic              unused_rdata;

   poll_timer #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .tick   (tick)
   );

   // Only the LED-width slice of the buttons register is mirrored.
   assign unused_rdata = ^bus.avm_readdata[AVM_DATA_W-1:LED_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      sample_d    = sample_q;
      to_cnt_d    = to_cnt_q;
      wr_done     = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && enable) state_d = RD_REQ;
         end
         RD_REQ: begin
            if (!bus.avm_waitrequest) begin
               state_d  = RD_WAIT;
               to_cnt_d = '0;
            end
         end
         RD_WAIT: begin
            if (bus.avm_readdatavalid) begin
               sample_d = bus.avm_readdata[LED_W-1:0];
               if (first_poll_q || (bus.avm_readdata[LED_W-1:0] != last_value))
                  state_d = WR_REQ;
               else
                  state_d = IDLE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d     = IDLE;
               timeout_hit = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         WR_REQ: begin
            if (!bus.avm_waitrequest) begin
               state_d = IDLE;
               wr_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Command follows the next state, so it stays frozen while a stall holds the state.
      cmd_d = cmd_for(state_d, BTN_ADDR, LED_ADDR, sample_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q     <= '0;
         to_cnt_q     <= '0;
         first_poll_q <= 1'b1;
         cmd_q        <= '0;
         busy         <= 1'b0;
         last_value   <= '0;
         change_pulse <= 1'b0;
         change_count <= '0;
         err_timeout  <= 1'b0;
      end else begin
         sample_q     <= sample_d;
         to_cnt_q     <= to_cnt_d;
         cmd_q        <= cmd_d;
         busy         <= (state_d != IDLE);
         change_pulse <= wr_done;
         if (wr_done) begin
            last_value   <= sample_q;
            first_poll_q <= 1'b0;
            change_count <= change_count + COUNT_W'(1);
         end
         if (timeout_hit) err_timeout <= 1'b1;
      end
   end

   assign bus.avm_address   = cmd_q.address;
   assign bus.avm_read      = cmd_q.read;
   assign bus.avm_write     = cmd_q.write;
   assign bus.avm_writedata = cmd_q.writedata;

endmodule
